pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Sits beside the decode-stage control unit and keeps its own shadow copy of the EX, MEM and WB stage tags.
- Generates per-stage enable/flush strobes, the PC redirect select and the EX operand forwarding selects.
- Resolves load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states; provides saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-index width
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs1, id_rs2  in  REG_AW each  decode source indices
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  REG_AW  decode destination
- id_regwrite, id_memread, id_memwrite  in  1 each  decode control (memwrite = |MemWrite)
- ex_redirect  in  1  branch taken or jump in EX
- dmem_ack  in  1  data memory completes the MEM-stage access this cycle
- pc_en  out  1  PC register load enable
- pc_sel_redirect  out  1  PC loads EX target instead of PC+4
- if_id_en, if_id_flush  out  1 each
- id_ex_en, id_ex_flush  out  1 each  (flush inserts a bubble)
- ex_mem_en, mem_wb_en  out  1 each
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 MEM ALU result, 10 WB result
- stall_cnt, flush_cnt  out  CNT_W each

Behaviour:
- Shadow tags per stage S in {EX, MEM, WB}: v, rd, wr, ld, st; EX also holds rs1, rs2. Reset: all v=0, all fields 0.
- mem_stall = MEM.v & (MEM.ld | MEM.st) & !dmem_ack.
- load_use = id_valid & EX.v & EX.ld & EX.rd!=0 & ((id_rs1_used & id_rs1==EX.rd) | (id_rs2_used & id_rs2==EX.rd)).
- redirect = EX.v & ex_redirect.
- Priority, evaluated combinationally each cycle:
  - mem_stall: all enables 0, all flushes 0, pc_sel_redirect 0. Shadows hold. A pending redirect is held in EX and taken after the ack.
  - else redirect: pc_en=1, pc_sel_redirect=1, if_id_flush=1, id_ex_flush=1; EX/MEM/WB enables 1. EX shadow v←0, MEM←EX, WB←MEM. Redirect overrides a simultaneous load_use.
  - else load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. EX.v←0, MEM←EX, WB←MEM.
  - else: all enables 1, flushes 0. EX←decode inputs (v=id_valid), MEM←EX, WB←MEM.
- Flush has precedence over enable on the same register.
- Forwarding (EX operand A uses EX.rs1, B uses EX.rs2; combinational, independent of stall):
  - 01 if MEM.v & MEM.wr & !MEM.ld & MEM.rd!=0 & MEM.rd==rs.
  - else 10 if WB.v & WB.wr & WB.rd!=0 & WB.rd==rs.
  - else 00. MEM has priority over WB. Reads of x0 never forward.
- Outputs are combinational from shadows and inputs. Out of reset (all v=0, no stall): pc_en=if_id_en=id_ex_en=ex_mem_en=mem_wb_en=1, all flushes 0, pc_sel_redirect 0, fwd 00, counters 0.
- Counters:
  - stall_cnt +1 on every cycle with mem_stall | load_use (redirect cycles excluded).
  - flush_cnt +1 on every redirect cycle.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-stall: all shadows invalid and counters 0 immediately (asynchronous). After release, the first cycle is a normal advance.

Test Plan:
- Reset → all enables 1, all flushes 0, fwd 00, counters 0; assert rst_n low mid-load_use stall → outputs return to reset values the same cycle.
- lw x5 in EX, decode add x6,x5,x1 (rs1_used) → one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1. Next cycle: advance, fwd_a_sel=10. Same case with rd=x0 → no stall.
- EX branch valid with ex_redirect=1 → pc_sel_redirect=1, if_id_flush=id_ex_flush=1, flush_cnt=1, next EX.v=0. Simultaneous load_use → redirect only, stall_cnt unchanged.
- Load in MEM with dmem_ack=0 for 3 cycles plus ex_redirect=1 → 3 frozen cycles, stall_cnt=3, no flush. On the ack cycle → redirect taken, flush_cnt=1.
- add x7 in MEM and add x7 in WB, EX reads x7 as rs1 and rs2 → fwd_a_sel=fwd_b_sel=01. MEM entry a load → 10. MEM.wr=0 → 10.
- CNT_W=4, 20 consecutive stall cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for a 5-stage RV32I pipeline: stall/flush strobes,
// PC redirect select, EX operand forwarding and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              ex_redirect,
    input  logic              dmem_ack,
    output logic              pc_en,
    output logic              pc_sel_redirect,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
        logic              st;
    } tag_t;

    tag_t              ex_q, mem_q, wb_q;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic              mem_stall, load_use, redirect;

    assign mem_stall = mem_q.v & (mem_q.ld | mem_q.st) & ~dmem_ack;
    assign redirect  = ex_q.v & ex_redirect;
    assign load_use  = id_valid & ex_q.v & ex_q.ld & (ex_q.rd != '0) &
                       ((id_rs1_used & (id_rs1 == ex_q.rd)) |
                        (id_rs2_used & (id_rs2 == ex_q.rd)));

    always_comb begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b0;
        if_id_en        = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_en        = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_en       = 1'b1;
        mem_wb_en       = 1'b1;
        if (mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (redirect) begin
            pc_sel_redirect = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // MEM forwards only ALU results; a load's data is not ready until WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input tag_t m, input tag_t w);
        if (m.v && m.wr && !m.ld && m.rd != '0 && m.rd == rs) return 2'b01;
        if (w.v && w.wr && w.rd != '0 && w.rd == rs)          return 2'b10;
        return 2'b00;
    endfunction

    assign fwd_a_sel = fwd_sel(ex_rs1, mem_q, wb_q);
    assign fwd_b_sel = fwd_sel(ex_rs2, mem_q, wb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (!mem_stall) begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (redirect || load_use) begin
                ex_q <= '0;
            end else begin
                ex_q   <= '{v: id_valid, rd: id_rd, wr: id_regwrite,
                            ld: id_memread, st: id_memwrite};
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
            end
        end
    end

    // A redirect suppressed by a memory stall is neither a stall-free flush nor a load_use stall.
    logic stall_inc, flush_inc;
    assign stall_inc = mem_stall | (load_use & ~redirect);
    assign flush_inc = redirect & ~mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; 4-bit counters make saturation reachable.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_rs1_used, id_rs2_used;
    logic              id_regwrite, id_memread, id_memwrite;
    logic              ex_redirect, dmem_ack;
    logic              pc_en, pc_sel_redirect, if_id_en, if_id_flush;
    logic              id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int vectors = 0;
    int errors  = 0;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .ex_redirect(ex_redirect), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
        #1;
    endtask

    task automatic do_reset();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b0;
        dmem_ack    = 1'b1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_redirect = 1'b0;
        dmem_ack = 1'b1;
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        rst_n = 1'b1;
        #1;
        // Reset state
        chk("rst_pc_en",  {31'd0, pc_en}, 1);
        chk("rst_enables", {27'd0, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_redirect}, 5'b11110);
        chk("rst_flushes", {30'd0, if_id_flush, id_ex_flush}, 0);
        chk("rst_fwd",     {28'd0, fwd_a_sel, fwd_b_sel}, 0);
        chk("rst_cnts",    {24'd0, stall_cnt, flush_cnt}, 0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in decode
        tick();
        dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        dec(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("lu_pc_en",    {31'd0, pc_en}, 0);
        chk("lu_if_id_en", {31'd0, if_id_en}, 0);
        chk("lu_id_ex_fl", {31'd0, id_ex_flush}, 1);
        chk("lu_ex_mem",   {30'd0, ex_mem_en, mem_wb_en}, 2'b11);
        tick();
        chk("lu_stall_cnt", {28'd0, stall_cnt}, 1);
        chk("lu_adv_pc_en", {31'd0, pc_en}, 1);
        tick();
        chk("lu_fwd_a",     {30'd0, fwd_a_sel}, 2'b10);
        chk("lu_fwd_b",     {30'd0, fwd_b_sel}, 2'b00);

        // Load to x0 never stalls
        do_reset();
        dec(1, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        dec(1, 0, 1, 1, 1, 6, 1, 0, 0);
        chk("x0_pc_en",  {31'd0, pc_en}, 1);
        chk("x0_flush",  {31'd0, id_ex_flush}, 0);

        // Redirect from EX
        do_reset();
        dec(1, 1, 2, 1, 1, 0, 0, 0, 0);
        tick();
        ex_redirect = 1'b1;
        dec(1, 3, 4, 1, 1, 9, 1, 0, 0);
        chk("br_sel",     {31'd0, pc_sel_redirect}, 1);
        chk("br_flushes", {30'd0, if_id_flush, id_ex_flush}, 2'b11);
        chk("br_pc_en",   {31'd0, pc_en}, 1);
        tick();
        chk("br_flush_cnt", {28'd0, flush_cnt}, 1);
        chk("br_ex_bubble", {31'd0, pc_sel_redirect}, 0);
        ex_redirect = 1'b0;

        // Redirect beats simultaneous load_use
        do_reset();
        dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        ex_redirect = 1'b1;
        dec(1, 5, 0, 1, 0, 6, 1, 0, 0);
        chk("brlu_sel",   {31'd0, pc_sel_redirect}, 1);
        chk("brlu_pc_en", {31'd0, pc_en}, 1);
        tick();
        chk("brlu_cnts",  {24'd0, stall_cnt, flush_cnt}, {24'd0, 4'd0, 4'd1});
        ex_redirect = 1'b0;

        // Memory wait with pending redirect
        do_reset();
        dec(1, 0, 0, 0, 0, 3, 1, 1, 0);
        tick();
        dec(1, 1, 2, 0, 0, 0, 0, 0, 0);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b1;
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ms_frozen", {26'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_redirect}, 0);
            chk("ms_noflush", {30'd0, if_id_flush, id_ex_flush}, 0);
            tick();
        end
        chk("ms_cnts", {24'd0, stall_cnt, flush_cnt}, {24'd0, 4'd3, 4'd0});
        dmem_ack = 1'b1;
        #1;
        chk("ms_ack_sel", {31'd0, pc_sel_redirect}, 1);
        tick();
        chk("ms_ack_flush_cnt", {28'd0, flush_cnt}, 1);
        ex_redirect = 1'b0;

        // Forwarding priority
        do_reset();
        dec(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        tick();
        dec(1, 7, 7, 1, 1, 8, 1, 0, 0);
        tick();
        chk("fw_mem_a", {30'd0, fwd_a_sel}, 2'b01);
        chk("fw_mem_b", {30'd0, fwd_b_sel}, 2'b01);

        do_reset();
        dec(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        dec(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        dec(1, 7, 7, 0, 0, 8, 1, 0, 0);
        tick();
        chk("fw_memld_a", {30'd0, fwd_a_sel}, 2'b10);
        chk("fw_memld_b", {30'd0, fwd_b_sel}, 2'b10);

        do_reset();
        dec(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        dec(1, 0, 0, 0, 0, 7, 0, 0, 0);
        tick();
        dec(1, 7, 3, 1, 1, 8, 1, 0, 0);
        tick();
        chk("fw_memnowr_a", {30'd0, fwd_a_sel}, 2'b10);
        chk("fw_memnowr_b", {30'd0, fwd_b_sel}, 2'b00);

        // Reset asserted during a load_use stall
        do_reset();
        dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        dec(1, 5, 0, 1, 0, 6, 1, 0, 0);
        tick();
        dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        dec(1, 5, 0, 1, 0, 6, 1, 0, 0);
        chk("rlu_stalled", {31'd0, pc_en}, 0);
        chk("rlu_cnt_pre", {28'd0, stall_cnt}, 1);
        rst_n = 1'b0;
        #1;
        chk("rlu_pc_en",  {30'd0, pc_en, if_id_en}, 2'b11);
        chk("rlu_flush",  {31'd0, id_ex_flush}, 0);
        chk("rlu_cnt",    {24'd0, stall_cnt, flush_cnt}, 0);
        rst_n = 1'b1;
        #1;
        chk("rlu_adv",    {29'd0, pc_en, if_id_en, id_ex_en}, 3'b111);

        // Counter saturation: 20 memory-stall cycles on a 4-bit counter
        do_reset();
        dec(1, 0, 0, 0, 0, 4, 1, 1, 0);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        dmem_ack = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", {28'd0, stall_cnt}, 15);
        dmem_ack = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
